// File: rtl/hms_timer.sv
// H:M:S stopwatch / countdown timer with button preset entry, done flag and
// optional lap capture (compiled in when LAP_CAPTURE_EN is defined).
module hms_timer #(
  parameter int unsigned HOUR_MAX = 12,
  parameter int unsigned HOUR_W   = 5
) (
  input  logic              clk_1Hz,
  input  logic              resetn,
  input  logic              start_stop,
  input  logic              mode_in,
  input  logic              dir_in,
  input  logic              hour_in,
  input  logic              min_in,
  input  logic              sec_in,
  input  logic              lap_in,
  output logic [HOUR_W-1:0] hour_out,
  output logic [5:0]        min_out,
  output logic [5:0]        sec_out,
  output logic              done,
  output logic [HOUR_W-1:0] lap_hour,
  output logic [5:0]        lap_min,
  output logic [5:0]        lap_sec,
  output logic              lap_valid
);

  localparam int unsigned FIELD_W = 6;
  localparam logic [FIELD_W-1:0] FIELD_LAST = FIELD_W'(59);
  localparam logic [HOUR_W-1:0]  HOUR_TERM  = HOUR_W'(HOUR_MAX);
  localparam logic [HOUR_W-1:0]  HOUR_LAST  = HOUR_W'(HOUR_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [HOUR_W-1:0]  preset_hour_q, preset_hour_d;
  logic [FIELD_W-1:0] preset_min_q,  preset_min_d;
  logic [FIELD_W-1:0] preset_sec_q,  preset_sec_d;
  logic [HOUR_W-1:0]  cnt_hour_q,    cnt_hour_d;
  logic [FIELD_W-1:0] cnt_min_q,     cnt_min_d;
  logic [FIELD_W-1:0] cnt_sec_q,     cnt_sec_d;
  logic               dir_q,         dir_d;
  logic               done_q,        done_d;

  logic               any_pulse;
  logic               preset_zero;
  logic               start_req;
  logic               tick_en;

  logic [HOUR_W-1:0]  up_hour,   down_hour;
  logic [FIELD_W-1:0] up_min,    down_min;
  logic [FIELD_W-1:0] up_sec,    down_sec;
  logic               up_term,   down_term;

  assign any_pulse   = hour_in | min_in | sec_in;
  assign preset_zero = (preset_hour_q == '0) && (preset_min_q == '0) && (preset_sec_q == '0);
  assign start_req   = !mode_in && !any_pulse && start_stop;
  assign tick_en     = (state_q == S_RUN) && !mode_in && start_stop;

  // Count-up successor with seconds->minutes->hours carry
  always_comb begin
    up_hour = cnt_hour_q;
    up_min  = cnt_min_q;
    up_sec  = cnt_sec_q + FIELD_W'(1);
    if (cnt_sec_q == FIELD_LAST) begin
      up_sec = '0;
      if (cnt_min_q == FIELD_LAST) begin
        up_min  = '0;
        up_hour = cnt_hour_q + HOUR_W'(1);
      end else begin
        up_min = cnt_min_q + FIELD_W'(1);
      end
    end
  end

  assign up_term = (up_hour == HOUR_TERM) && (up_min == '0) && (up_sec == '0);

  // Count-down predecessor with borrow; 0:00:00 is never ticked from
  always_comb begin
    down_hour = cnt_hour_q;
    down_min  = cnt_min_q;
    down_sec  = cnt_sec_q - FIELD_W'(1);
    if (cnt_sec_q == '0) begin
      down_sec = FIELD_LAST;
      if (cnt_min_q == '0) begin
        down_min  = FIELD_LAST;
        down_hour = cnt_hour_q - HOUR_W'(1);
      end else begin
        down_min = cnt_min_q - FIELD_W'(1);
      end
    end
  end

  assign down_term = (cnt_hour_q == '0) && (cnt_min_q == '0) && (cnt_sec_q == FIELD_W'(1));

  always_ff @(posedge clk_1Hz) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d = (dir_in && preset_zero) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (mode_in) begin
          state_d = S_IDLE;
        end else if (!start_stop) begin
          state_d = S_PAUSE;
        end else if (dir_q ? down_term : up_term) begin
          state_d = S_DONE;
        end
      end
      S_PAUSE: begin
        if (mode_in) begin
          state_d = S_IDLE;
        end else if (start_stop) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (mode_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Preset entry, direction latch, count datapath and done flag
  always_comb begin
    preset_hour_d = preset_hour_q;
    preset_min_d  = preset_min_q;
    preset_sec_d  = preset_sec_q;
    cnt_hour_d    = cnt_hour_q;
    cnt_min_d     = cnt_min_q;
    cnt_sec_d     = cnt_sec_q;
    dir_d         = dir_q;
    done_d        = (state_d == S_DONE);

    if (state_q == S_IDLE) begin
      if (mode_in) begin
        preset_hour_d = '0;
        preset_min_d  = '0;
        preset_sec_d  = '0;
      end else begin
        if (hour_in) begin
          preset_hour_d = (preset_hour_q == HOUR_LAST) ? '0 : preset_hour_q + HOUR_W'(1);
        end
        if (min_in) begin
          preset_min_d = (preset_min_q == FIELD_LAST) ? '0 : preset_min_q + FIELD_W'(1);
        end
        if (sec_in) begin
          preset_sec_d = (preset_sec_q == FIELD_LAST) ? '0 : preset_sec_q + FIELD_W'(1);
        end
        if (start_req) begin
          dir_d = dir_in;
        end
      end
    end

    // In IDLE (and on the edge returning to it) the display mirrors the preset
    if (state_d == S_IDLE) begin
      cnt_hour_d = preset_hour_d;
      cnt_min_d  = preset_min_d;
      cnt_sec_d  = preset_sec_d;
    end else if (tick_en) begin
      cnt_hour_d = dir_q ? down_hour : up_hour;
      cnt_min_d  = dir_q ? down_min  : up_min;
      cnt_sec_d  = dir_q ? down_sec  : up_sec;
    end
  end

  always_ff @(posedge clk_1Hz) begin
    if (!resetn) begin
      preset_hour_q <= '0;
      preset_min_q  <= '0;
      preset_sec_q  <= '0;
      cnt_hour_q    <= '0;
      cnt_min_q     <= '0;
      cnt_sec_q     <= '0;
      dir_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      preset_hour_q <= preset_hour_d;
      preset_min_q  <= preset_min_d;
      preset_sec_q  <= preset_sec_d;
      cnt_hour_q    <= cnt_hour_d;
      cnt_min_q     <= cnt_min_d;
      cnt_sec_q     <= cnt_sec_d;
      dir_q         <= dir_d;
      done_q        <= done_d;
    end
  end

  assign hour_out = cnt_hour_q;
  assign min_out  = cnt_min_q;
  assign sec_out  = cnt_sec_q;
  assign done     = done_q;

`ifdef LAP_CAPTURE_EN
  logic [HOUR_W-1:0]  lap_hour_q, lap_hour_d;
  logic [FIELD_W-1:0] lap_min_q,  lap_min_d;
  logic [FIELD_W-1:0] lap_sec_q,  lap_sec_d;
  logic               lap_valid_q, lap_valid_d;

  // Lap snapshot uses the pre-tick count; any return to IDLE clears it
  always_comb begin
    lap_hour_d  = lap_hour_q;
    lap_min_d   = lap_min_q;
    lap_sec_d   = lap_sec_q;
    lap_valid_d = lap_valid_q;
    if (state_d == S_IDLE) begin
      lap_hour_d  = '0;
      lap_min_d   = '0;
      lap_sec_d   = '0;
      lap_valid_d = 1'b0;
    end else if (lap_in && ((state_q == S_RUN) || (state_q == S_PAUSE))) begin
      lap_hour_d  = cnt_hour_q;
      lap_min_d   = cnt_min_q;
      lap_sec_d   = cnt_sec_q;
      lap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_1Hz) begin
    if (!resetn) begin
      lap_hour_q  <= '0;
      lap_min_q   <= '0;
      lap_sec_q   <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_hour_q  <= lap_hour_d;
      lap_min_q   <= lap_min_d;
      lap_sec_q   <= lap_sec_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_hour  = lap_hour_q;
  assign lap_min   = lap_min_q;
  assign lap_sec   = lap_sec_q;
  assign lap_valid = lap_valid_q;
`else
  logic unused_lap_in;
  assign unused_lap_in = lap_in;

  assign lap_hour  = '0;
  assign lap_min   = '0;
  assign lap_sec   = '0;
  assign lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_hms_timer.sv
// Scoreboard bench for hms_timer: expected display snapshots are queued as
// stimulus is driven and compared one edge later.
`timescale 1ns/1ps
module tb_hms_timer;

  localparam int unsigned HOUR_MAX = 12;
  localparam int unsigned HOUR_W   = 5;
`ifdef LAP_CAPTURE_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [5:0]        min;
    logic [5:0]        sec;
    logic              done;
    logic [HOUR_W-1:0] lap_hour;
    logic [5:0]        lap_min;
    logic [5:0]        lap_sec;
    logic              lap_valid;
  } snap_t;

  logic              clk_1Hz = 1'b0;
  logic              resetn = 1'b0;
  logic              start_stop = 1'b0;
  logic              mode_in = 1'b0;
  logic              dir_in = 1'b0;
  logic              hour_in = 1'b0;
  logic              min_in = 1'b0;
  logic              sec_in = 1'b0;
  logic              lap_in = 1'b0;
  logic [HOUR_W-1:0] hour_out;
  logic [5:0]        min_out;
  logic [5:0]        sec_out;
  logic              done;
  logic [HOUR_W-1:0] lap_hour;
  logic [5:0]        lap_min;
  logic [5:0]        lap_sec;
  logic              lap_valid;

  snap_t exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  hms_timer #(.HOUR_MAX(HOUR_MAX), .HOUR_W(HOUR_W)) dut (
    .clk_1Hz   (clk_1Hz),
    .resetn    (resetn),
    .start_stop(start_stop),
    .mode_in   (mode_in),
    .dir_in    (dir_in),
    .hour_in   (hour_in),
    .min_in    (min_in),
    .sec_in    (sec_in),
    .lap_in    (lap_in),
    .hour_out  (hour_out),
    .min_out   (min_out),
    .sec_out   (sec_out),
    .done      (done),
    .lap_hour  (lap_hour),
    .lap_min   (lap_min),
    .lap_sec   (lap_sec),
    .lap_valid (lap_valid)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  function automatic snap_t observe();
    return {hour_out, min_out, sec_out, done, lap_hour, lap_min, lap_sec, lap_valid};
  endfunction

  function automatic snap_t hms(int t, bit d);
    snap_t v = '0;
    v.hour = HOUR_W'(t / 3600);
    v.min  = 6'((t / 60) % 60);
    v.sec  = 6'(t % 60);
    v.done = d;
    return v;
  endfunction

  // Adds a lap snapshot of lap_t seconds, present only when lap capture is built in
  function automatic snap_t lapped(snap_t base, int lap_t);
    snap_t v = base;
    if (LAP_ON) begin
      v.lap_hour  = HOUR_W'(lap_t / 3600);
      v.lap_min   = 6'((lap_t / 60) % 60);
      v.lap_sec   = 6'(lap_t % 60);
      v.lap_valid = 1'b1;
    end
    return v;
  endfunction

  function automatic string fmt(snap_t v);
    return $sformatf("%0d:%0d:%0d done=%0b lap=%0d:%0d:%0d valid=%0b",
                     v.hour, v.min, v.sec, v.done, v.lap_hour, v.lap_min, v.lap_sec, v.lap_valid);
  endfunction

  task automatic push(string tag, snap_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic drive(bit ss, bit md, bit dr, bit hp, bit mp, bit sp, bit lp);
    start_stop = ss;
    mode_in    = md;
    dir_in     = dr;
    hour_in    = hp;
    min_in     = mp;
    sec_in     = sp;
    lap_in     = lp;
  endtask

  task automatic tick();
    @(posedge clk_1Hz);
    #1;
  endtask

  task automatic test_reset();
    snap_t got, e;
    string tag;
    for (int k = 0; k < 2; k++) begin
      resetn = (k != 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      push(k == 0 ? "reset" : "idle_after_reset", hms(0, 0));
      tick();
      got = observe(); e = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s got %s expected %s", tag, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_count_up();
    snap_t got, e;
    string tag;
    int    el;
    for (int t = 0; t <= 43200 + 6; t++) begin
      if (t <= 43205) begin
        el = (t > 43200) ? 43200 : t;
        drive(1, 0, 0, 0, 0, 0, 0);
        if (t inside {0, 1, 59, 60, 3599, 3600, 43199} || t >= 43200)
          push($sformatf("up_t%0d", t), hms(el, el == 43200));
      end else begin
        drive(0, 1, 0, 0, 0, 0, 0);
        push("up_done_to_idle", hms(0, 0));
      end
      tick();
      if (exp_q.size() != 0) begin
        got = observe(); e = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s got %s expected %s", tag, fmt(got), fmt(e));
        end
      end
    end
  endtask

  task automatic test_preset_countdown();
    snap_t got, e;
    string tag;
    localparam int TOTAL = 2 * 3600 + 60 + 5;
    int rem;
    for (int k = 0; k < 8 + TOTAL + 2 + 2; k++) begin
      if (k < 8) begin
        drive(0, 0, 0, k < 2, k == 2, k >= 3, 0);
        if (k == 1) push("preset_hours", hms(2 * 3600, 0));
        if (k == 7) push("preset_02_01_05", hms(TOTAL, 0));
      end else if (k < 8 + TOTAL + 2) begin
        rem = TOTAL - (k - 8);
        if (rem < 0) rem = 0;
        drive(1, 0, (k - 8) < 100, 0, 0, 0, 0);
        if ((k - 8) inside {0, 1, 5, 6, 65, 66, 100, TOTAL - 1, TOTAL, TOTAL + 1})
          push($sformatf("down_t%0d", k - 8), hms(rem, rem == 0));
      end else begin
        drive(0, 1, 0, 0, 0, 0, 0);
        push(k == 8 + TOTAL + 2 ? "down_mode_shows_preset" : "mode_held_clears_preset",
             hms(k == 8 + TOTAL + 2 ? TOTAL : 0, 0));
      end
      tick();
      if (exp_q.size() != 0) begin
        got = observe(); e = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s got %s expected %s", tag, fmt(got), fmt(e));
        end
      end
    end
  endtask

  task automatic test_preset_wrap();
    snap_t got, e;
    string tag;
    for (int k = 0; k <= 60 + HOUR_MAX + 2; k++) begin
      if (k == 0) begin
        drive(0, 0, 0, 0, 1, 0, 0);
        push("wrap_min1", hms(60, 0));
      end else if (k <= 60) begin
        drive(0, 0, 0, 0, 0, 1, 0);
        if (k == 59) push("wrap_sec59", hms(60 + 59, 0));
        if (k == 60) push("wrap_sec_to_0", hms(60, 0));
      end else if (k <= 60 + HOUR_MAX) begin
        drive(0, 0, 0, 1, 0, 0, 0);
        if (k == 60 + HOUR_MAX - 1) push("wrap_hour_last", hms((HOUR_MAX - 1) * 3600 + 60, 0));
        if (k == 60 + HOUR_MAX) push("wrap_hour_to_0", hms(60, 0));
      end else if (k == 60 + HOUR_MAX + 1) begin
        drive(0, 0, 0, 1, 1, 1, 0);
        push("simultaneous_pulses", hms(3600 + 120 + 1, 0));
      end else begin
        drive(0, 1, 0, 0, 0, 0, 0);
        push("wrap_clear", hms(0, 0));
      end
      tick();
      if (exp_q.size() != 0) begin
        got = observe(); e = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s got %s expected %s", tag, fmt(got), fmt(e));
        end
      end
    end
  endtask

  task automatic test_pause();
    snap_t got, e;
    string tag;
    for (int k = 0; k <= 18; k++) begin
      if (k <= 4) begin
        drive(0, 0, 0, 0, 0, 1, 0);
        if (k == 4) push("pause_preset5", hms(5, 0));
      end else if (k == 5) begin
        drive(1, 0, 0, 0, 0, 0, 0);
        push("pause_run_entry", hms(5, 0));
      end else if (k <= 10) begin
        drive(1, 0, 1, 0, 0, 0, 0);
        if (k == 10) push("run_dir_ignored", hms(10, 0));
      end else if (k <= 14) begin
        drive(0, 0, 0, 0, 0, k == 12, 0);
        push($sformatf("pause_hold%0d", k - 10), hms(10, 0));
      end else if (k == 15) begin
        drive(1, 0, 0, 0, 0, 0, 0);
        push("resume_edge", hms(10, 0));
      end else if (k == 16) begin
        drive(1, 0, 0, 0, 0, 0, 0);
        push("resume_tick", hms(11, 0));
      end else begin
        drive(0, 1, 0, 0, 0, 0, 0);
        push(k == 17 ? "run_mode_shows_preset" : "pause_clear", hms(k == 17 ? 5 : 0, 0));
      end
      tick();
      if (exp_q.size() != 0) begin
        got = observe(); e = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s got %s expected %s", tag, fmt(got), fmt(e));
        end
      end
    end
  endtask

  task automatic test_done();
    snap_t got, e;
    string tag;
    for (int k = 0; k <= 8; k++) begin
      case (k)
        0:       begin drive(1, 0, 1, 0, 0, 0, 0); push("zero_countdown_done", hms(0, 1)); end
        1:       begin drive(0, 0, 1, 0, 0, 0, 0); push("done_ss0", hms(0, 1)); end
        2:       begin drive(1, 0, 0, 0, 0, 0, 0); push("done_ss1", hms(0, 1)); end
        3:       begin drive(0, 1, 0, 0, 0, 0, 0); push("done_to_idle", hms(0, 0)); end
        4:       begin drive(1, 0, 0, 0, 0, 0, 0); push("run_entry", hms(0, 0)); end
        5:       begin drive(1, 0, 0, 0, 0, 0, 0); push("run_tick1", hms(1, 0)); end
        6:       begin drive(1, 1, 0, 0, 0, 0, 0); push("mode_and_start_run", hms(0, 0)); end
        7:       begin drive(1, 1, 0, 0, 0, 0, 0); push("mode_and_start_idle", hms(0, 0)); end
        default: begin drive(0, 0, 0, 0, 0, 0, 0); push("idle_stays", hms(0, 0)); end
      endcase
      tick();
      if (exp_q.size() != 0) begin
        got = observe(); e = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s got %s expected %s", tag, fmt(got), fmt(e));
        end
      end
    end
  endtask

  task automatic test_lap();
    snap_t got, e;
    string tag;
    for (int k = 0; k <= 99; k++) begin
      if (k <= 90) begin
        drive(1, 0, 0, 0, 0, 0, 0);
        if (k == 90) push("lap_pre", hms(90, 0));
      end else if (k == 91) begin
        drive(1, 0, 0, 0, 0, 0, 1);
        push("lap_on_tick", lapped(hms(91, 0), 90));
      end else if (k <= 94) begin
        drive(1, 0, 0, 0, 0, 0, 0);
        if (k == 94) push("lap_holds", lapped(hms(94, 0), 90));
      end else if (k == 95) begin
        drive(0, 0, 0, 0, 0, 0, 0);
        push("lap_pause", lapped(hms(94, 0), 90));
      end else if (k == 96) begin
        drive(0, 0, 0, 0, 0, 0, 1);
        push("lap_in_pause", lapped(hms(94, 0), 94));
      end else if (k == 97) begin
        drive(0, 1, 0, 0, 0, 0, 0);
        push("lap_cleared_idle", hms(0, 0));
      end else if (k == 98) begin
        drive(0, 0, 0, 0, 0, 0, 1);
        push("lap_ignored_idle", hms(0, 0));
      end else begin
        drive(0, 0, 0, 0, 0, 0, 0);
        push("lap_idle_quiet", hms(0, 0));
      end
      tick();
      if (exp_q.size() != 0) begin
        got = observe(); e = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s got %s expected %s", tag, fmt(got), fmt(e));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    snap_t got, e;
    string tag;
    for (int k = 0; k <= 7; k++) begin
      resetn = (k != 5);
      case (k)
        0:       begin drive(0, 0, 0, 0, 1, 0, 0); push("mid_preset", hms(60, 0)); end
        1:       begin drive(1, 0, 1, 0, 0, 0, 0); push("mid_run_entry", hms(60, 0)); end
        2:       drive(1, 0, 1, 0, 0, 0, 0);
        3:       drive(1, 0, 1, 0, 0, 0, 1);
        4:       begin drive(1, 0, 1, 0, 0, 0, 0); push("mid_countdown", lapped(hms(57, 0), 59)); end
        5:       begin drive(1, 0, 1, 0, 0, 0, 0); push("mid_reset", hms(0, 0)); end
        6:       begin drive(0, 0, 0, 0, 0, 1, 0); push("preset_cleared_by_reset", hms(1, 0)); end
        default: begin drive(0, 1, 0, 0, 0, 0, 0); push("mid_clear", hms(0, 0)); end
      endcase
      tick();
      if (exp_q.size() != 0) begin
        got = observe(); e = exp_q.pop_front(); tag = tag_q.pop_front(); checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s got %s expected %s", tag, fmt(got), fmt(e));
        end
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_preset_countdown();
    test_preset_wrap();
    test_pause();
    test_done();
    test_lap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
